ecpdly_calibrate: RTL

Closed-loop calibration engine that drives the commanded-delay input of a programmable I/O delay controller and reads back its current delay. It sweeps every tap from 0 to MAXDLY and scores each tap with a data-checker match strobe. It then finds the widest contiguous passing window and parks the delay at that window's centre. It sits between the delay controller and a pattern checker on the receive path, and is started by software or the reset sequencer.

---
 rtl/ecpdly_calibrate.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/ecpdly_calibrate.sv
// Closed-loop I/O delay calibration: sweeps taps 0..MAXDLY, scores each with the checker strobe,
// and parks the delay at the centre of the widest passing window. Optional scan map: ECPDLY_CALIBRATE_SCANMAP_EN.
module ecpdly_calibrate #(
   parameter int NBITS     = 16,
   parameter int MAXDLY    = 127,
   parameter int LGSETTLE  = 4,
   parameter int LGSAMPLE  = 8,
   parameter int LGTIMEOUT = 12
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [NBITS-1:0] i_current_delay,
   input  logic             i_match,
   output logic [NBITS-1:0] o_commanded_delay,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_fail,
   output logic [NBITS-1:0] o_best_delay,
   output logic [NBITS-1:0] o_window,
   input  logic [NBITS-1:0] i_map_addr,
   output logic             o_map_pass
);

   // Handshake: i_start is a level sampled only in IDLE; o_done/o_fail are sticky until the next accepted start.
   localparam int CW = ((LGSETTLE > LGSAMPLE) ? LGSETTLE : LGSAMPLE) + 1;
   localparam logic [CW-1:0]    SETTLE_LAST = CW'((1 << LGSETTLE) - 1);
   localparam logic [CW-1:0]    SAMPLE_LAST = CW'((1 << LGSAMPLE) - 1);
   localparam logic [NBITS-1:0] LAST_TAP    = NBITS'(MAXDLY);

   typedef enum logic [2:0] {
      S_IDLE, S_MOVE, S_SETTLE, S_SAMPLE, S_NEXT, S_CENTER, S_FINISH
   } state_t;

   state_t               state;
   logic [NBITS-1:0]     tap;
   logic [NBITS-1:0]     run_start, run_len;
   logic [NBITS-1:0]     best_start, best_len;
   logic [CW-1:0]        cnt;
   logic [LGTIMEOUT-1:0] tmo;
   logic                 tap_pass;
   logic                 arrived;
   logic                 start_ok;

   logic [NBITS-1:0]     nrun_start, nrun_len;
   logic [NBITS-1:0]     nbest_start, nbest_len;
   logic [NBITS-1:0]     center_tap;

   assign arrived  = (i_current_delay == o_commanded_delay);
   assign start_ok = (state == S_IDLE) && i_start;

   // Window bookkeeping for the tap just scored; the final tap's result feeds the centre directly.
   always_comb begin
      nrun_start  = run_start;
      nrun_len    = run_len;
      nbest_start = best_start;
      nbest_len   = best_len;
      if (tap_pass) begin
         if (run_len == '0)
            nrun_start = tap;
         nrun_len = run_len + 1'b1;
      end else begin
         nrun_len = '0;
      end
      if (nrun_len > best_len) begin
         nbest_start = nrun_start;
         nbest_len   = nrun_len;
      end
      center_tap = nbest_start + ((nbest_len - 1'b1) >> 1);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state             <= S_IDLE;
         tap               <= '0;
         run_start         <= '0;
         run_len           <= '0;
         best_start        <= '0;
         best_len          <= '0;
         cnt               <= '0;
         tmo               <= '0;
         tap_pass          <= 1'b0;
         o_commanded_delay <= '0;
         o_busy            <= 1'b0;
         o_done            <= 1'b0;
         o_fail            <= 1'b0;
         o_best_delay      <= '0;
         o_window          <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  state             <= S_MOVE;
                  tap               <= '0;
                  o_commanded_delay <= '0;
                  o_busy            <= 1'b1;
                  o_done            <= 1'b0;
                  o_fail            <= 1'b0;
                  run_start         <= '0;
                  run_len           <= '0;
                  best_start        <= '0;
                  best_len          <= '0;
                  o_best_delay      <= '0;
                  o_window          <= '0;
                  cnt               <= '0;
                  tmo               <= '0;
               end
            end
            S_MOVE: begin
               if (arrived) begin
                  state <= S_SETTLE;
                  cnt   <= '0;
               end else if (&tmo) begin
                  o_fail            <= 1'b1;
                  o_commanded_delay <= '0;
                  state             <= S_FINISH;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            S_SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  cnt      <= '0;
                  tap_pass <= 1'b1;
                  state    <= S_SAMPLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_SAMPLE: begin
               tap_pass <= tap_pass & i_match;
               if (cnt == SAMPLE_LAST) begin
                  cnt   <= '0;
                  state <= S_NEXT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_NEXT: begin
               run_start  <= nrun_start;
               run_len    <= nrun_len;
               best_start <= nbest_start;
               best_len   <= nbest_len;
               tmo        <= '0;
               if (tap == LAST_TAP) begin
                  state    <= S_CENTER;
                  o_window <= nbest_len;
                  if (nbest_len == '0) begin
                     o_fail            <= 1'b1;
                     o_commanded_delay <= '0;
                     o_best_delay      <= '0;
                  end else begin
                     o_commanded_delay <= center_tap;
                     o_best_delay      <= center_tap;
                  end
               end else begin
                  tap               <= tap + 1'b1;
                  o_commanded_delay <= tap + 1'b1;
                  state             <= S_MOVE;
               end
            end
            S_CENTER: begin
               if (arrived) begin
                  state <= S_FINISH;
               end else if (&tmo) begin
                  o_fail            <= 1'b1;
                  o_commanded_delay <= '0;
                  state             <= S_FINISH;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            S_FINISH: begin
               o_done <= 1'b1;
               o_busy <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef ECPDLY_CALIBRATE_SCANMAP_EN
   localparam int AW = (MAXDLY < 1) ? 1 : $clog2(MAXDLY + 1);

   logic [MAXDLY:0] scan_map;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         scan_map   <= '0;
         o_map_pass <= 1'b0;
      end else begin
         if (start_ok)
            scan_map <= '0;
         else if (state == S_NEXT)
            scan_map[tap[AW-1:0]] <= tap_pass;
         o_map_pass <= (i_map_addr <= LAST_TAP) ? scan_map[i_map_addr[AW-1:0]] : 1'b0;
      end
   end
`else
   logic unused_map_addr;
   logic unused_start_ok;

   assign unused_map_addr = ^i_map_addr;
   assign unused_start_ok = start_ok;
   assign o_map_pass      = 1'b0;
`endif

endmodule
